// File: rtl/sp_ram_reader_pkg.sv
// sp_ram_reader_pkg: FSM states and sizing shared by the RAM read initiator and its FIFO
package sp_ram_reader_pkg;
    typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
    localparam int FIFO_DEPTH = 4;
    localparam int OUT_W = 3;
endpackage

// File: rtl/sp_ram_reader_fifo.sv
// sp_ram_reader_fifo: 4-entry synchronous FIFO with same-cycle push and pop
// Ports: clk, rst (sync, active-high), clr (drop all entries), push/din, pop/dout (head), empty, full.
module sp_ram_reader_fifo #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    import sp_ram_reader_pkg::*;
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef logic [PW:0] cnt_t;
    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic [W-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    cnt_t cnt_q, cnt_d;
    logic do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full = cnt_q == cnt_t'(FIFO_DEPTH);
    assign dout = mem_q[rd_q];
    assign do_pop = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && !clr && (!full || do_pop);
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = clr ? '0 : wr_q + PW'(do_push);
        rd_d = clr ? '0 : rd_q + PW'(do_pop);
        cnt_d = clr ? '0 : cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
    end
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/sp_ram_reader.sv
// sp_ram_reader: walks a contiguous RAM address range and presents the words as a valid/ready stream
// Optional feature: define SP_RAM_READER_ABORT_EN to add the abort input.
// Ports: clk, rst (sync, active-high); start/start_addr/len command; busy/done status;
//        ram_en/ram_we/ram_addr/ram_data_in/ram_data_out to a 1-cycle-latency RAM;
//        m_valid/m_ready/m_data/m_last stream out; abort (optional) cancels a transfer.
module sp_ram_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SP_RAM_READER_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    import sp_ram_reader_pkg::*;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic pend_q, pend_d, pend_last_q, pend_last_d, done_q, done_d;
    logic kill, issue, pop, accept, fifo_empty, fifo_full, head_last;
    logic [DATA_W-1:0] head_data;
`ifdef SP_RAM_READER_ABORT_EN
    assign kill = abort && state_q != IDLE;
`else
    assign kill = 1'b0;
`endif
    // outstanding covers words in the RAM pipeline plus words in the FIFO, so capping it
    // at the FIFO depth guarantees every issued read has a slot waiting for it
    assign issue = state_q == READ && rem_q != '0 && out_q < OUT_W'(FIFO_DEPTH) && !fifo_full && !kill;
    assign pop = m_valid && m_ready;
    // the done cycle already shows IDLE, but a start there must still be ignored
    assign accept = state_q == IDLE && start && !done_q;
    always_comb begin
        state_d = state_q;
        addr_d = issue ? addr_q + ADDR_W'(1) : addr_q;
        rem_d = issue ? rem_q - LEN_W'(1) : rem_q;
        out_d = kill ? '0 : out_q + OUT_W'(issue) - OUT_W'(pop);
        pend_d = issue;
        pend_last_d = issue && rem_q == LEN_W'(1);
        done_d = (state_q == FLUSH || kill) && out_d == '0;
        if (accept) begin
            addr_d = start_addr;
            rem_d = len;
            state_d = len == '0 ? FLUSH : READ;
        end else if (kill || (state_q == FLUSH && out_d == '0)) begin
            state_d = IDLE;
        end else if (pend_last_d) begin
            state_d = FLUSH;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q <= '0;
            rem_q <= '0;
            out_q <= '0;
            pend_q <= 1'b0;
            pend_last_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            rem_q <= rem_d;
            out_q <= out_d;
            pend_q <= pend_d && !kill;
            pend_last_q <= pend_last_d;
            done_q <= done_d;
        end
    end
    sp_ram_reader_fifo #(.W(DATA_W + 1)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clr(kill),
        .push(pend_q),
        .din({pend_last_q, ram_data_out}),
        .pop(pop),
        .dout({head_last, head_data}),
        .empty(fifo_empty),
        .full(fifo_full)
    );
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign ram_en = issue;
    assign ram_we = 1'b0;
    assign ram_addr = addr_q;
    assign ram_data_in = '0;
    assign m_valid = !fifo_empty;
    assign m_data = m_valid ? head_data : '0;
    assign m_last = m_valid && head_last;
endmodule

// File: tb/tb_sp_ram_reader.sv
// tb_sp_ram_reader: directed self-checking bench for sp_ram_reader
module tb_sp_ram_reader;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int LW = 15;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic m_ready = 1'b1;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] len = '0;
    logic busy, done, ram_en, ram_we, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in, m_data;
    logic [DW-1:0] ram_data_out = '0;
`ifdef SP_RAM_READER_ABORT_EN
    logic abort = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem [1 << AW];
    int cur_c = -1;
    int en_cyc [$];
    logic [AW-1:0] en_addr [$];
    logic [DW-1:0] wd [$];
    logic wl [$];
    int done_cnt = 0;
    logic prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    typedef struct {
        logic start, rdy, busy, done, en;
        logic [AW-1:0] addr;
        logic mv;
        logic [DW-1:0] data;
        logic last;
    } vec_t;
    vec_t tv [13];

    sp_ram_reader dut (
        .clk(clk),
        .rst(rst),
`ifdef SP_RAM_READER_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .start_addr(start_addr),
        .len(len),
        .busy(busy),
        .done(done),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_en) ram_data_out <= mem[ram_addr];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_en) begin
            en_cyc.push_back(cur_c);
            en_addr.push_back(ram_addr);
            chk("ram_we", {31'b0, ram_we}, 0);
            chk("ram_data_in", {24'b0, ram_data_in}, 0);
        end
        if (m_valid && m_ready) begin
            wd.push_back(m_data);
            wl.push_back(m_last);
        end
        if (done) done_cnt++;
        if (prev_stall && !rst) chk("stall_hold", {23'b0, m_valid, m_data}, {23'b0, 1'b1, prev_data});
        prev_stall = m_valid && !m_ready && !rst;
        prev_data = m_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    function automatic vec_t v(bit st, bit rdy, bit b, bit d, bit e, int a, bit mv, int dt, bit l);
        vec_t r;
        r.start = st; r.rdy = rdy; r.busy = b; r.done = d; r.en = e;
        r.addr = a[AW-1:0]; r.mv = mv; r.data = dt[DW-1:0]; r.last = l;
        return r;
    endfunction

    task automatic clear_logs();
        en_cyc.delete();
        en_addr.delete();
        wd.delete();
        wl.delete();
        done_cnt = 0;
    endtask

    // cycle 0 carries start; rs_c re-pulses start with a different command that must be ignored
    task automatic xfer(input logic [AW-1:0] sa, input logic [LW-1:0] n, input int lo_a, input int lo_b,
                        input int rs_c, output int dc, output logic b1);
        clear_logs();
        dc = -1;
        b1 = 1'b0;
        for (int c = 0; c < 300 && dc < 0; c++) begin
            @(posedge clk); #1;
            cur_c = c;
            start = (c == 0) || (c == rs_c);
            start_addr = (c == 0) ? sa : 14'h2000;
            len = (c == 0) ? n : 15'd5;
            m_ready = !(c >= lo_a && c <= lo_b);
            @(negedge clk);
            if (c == 1) b1 = busy;
            if (done) dc = c;
        end
        @(posedge clk); #1;
        start = 1'b0;
        m_ready = 1'b1;
        cur_c = -1;
        chk("done_seen", {31'b0, dc >= 0}, 1);
    endtask

    int dc;
    logic b1;
    int n;
    logic [AW-1:0] wrap_a [4];
    logic [DW-1:0] wrap_d [4];

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = i[DW-1:0];
        tv[0]  = v(1, 1, 0, 0, 0, 'h00, 0, 'h00, 0);
        tv[1]  = v(0, 1, 1, 0, 1, 'h10, 0, 'h00, 0);
        tv[2]  = v(0, 1, 1, 0, 1, 'h11, 0, 'h00, 0);
        tv[3]  = v(0, 1, 1, 0, 1, 'h12, 1, 'h10, 0);
        tv[4]  = v(0, 1, 1, 0, 1, 'h13, 1, 'h11, 0);
        tv[5]  = v(0, 1, 1, 0, 1, 'h14, 1, 'h12, 0);
        tv[6]  = v(0, 1, 1, 0, 1, 'h15, 1, 'h13, 0);
        tv[7]  = v(0, 1, 1, 0, 1, 'h16, 1, 'h14, 0);
        tv[8]  = v(0, 1, 1, 0, 1, 'h17, 1, 'h15, 0);
        tv[9]  = v(0, 1, 1, 0, 0, 'h00, 1, 'h16, 0);
        tv[10] = v(0, 1, 1, 0, 0, 'h00, 1, 'h17, 1);
        tv[11] = v(0, 1, 0, 1, 0, 'h00, 0, 'h00, 0);
        tv[12] = v(0, 1, 0, 0, 0, 'h00, 0, 'h00, 0);
        wrap_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        wrap_d = '{8'hFE, 8'hFF, 8'h00, 8'h01};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        start_addr = 14'h10;
        len = 15'd8;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            cur_c = i;
            start = tv[i].start;
            m_ready = tv[i].rdy;
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", i), busy, tv[i].busy);
            chk($sformatf("t1_done_c%0d", i), done, tv[i].done);
            chk($sformatf("t1_en_c%0d", i), ram_en, tv[i].en);
            chk($sformatf("t1_valid_c%0d", i), m_valid, tv[i].mv);
            chk($sformatf("t1_last_c%0d", i), m_last, tv[i].last);
            if (tv[i].en) chk($sformatf("t1_addr_c%0d", i), ram_addr, tv[i].addr);
            if (tv[i].mv) chk($sformatf("t1_data_c%0d", i), m_data, tv[i].data);
        end
        start = 1'b0;

        xfer(14'h10, 15'd8, 3, 9, -1, dc, b1);
        n = 0;
        foreach (en_cyc[i]) if (en_cyc[i] <= 9) n++;
        chk("t2_en_before_stall", n, 4);
        chk("t2_en_total", en_cyc.size(), 8);
        if (en_cyc.size() > 4) chk("t2_resume_cycle", en_cyc[4], 11);
        chk("t2_words", wd.size(), 8);
        foreach (wd[i]) chk($sformatf("t2_data_%0d", i), wd[i], 'h10 + i);
        foreach (wl[i]) chk($sformatf("t2_last_%0d", i), wl[i], i == 7);
        chk("t2_done_cycle", dc, 18);

        xfer(14'h3FFE, 15'd4, -1, -1, 2, dc, b1);
        chk("t3_en_count", en_addr.size(), 4);
        foreach (en_addr[i]) if (i < 4) chk($sformatf("t3_addr_%0d", i), en_addr[i], wrap_a[i]);
        chk("t3_words", wd.size(), 4);
        foreach (wd[i]) if (i < 4) chk($sformatf("t3_data_%0d", i), wd[i], wrap_d[i]);
        foreach (wl[i]) chk($sformatf("t3_last_%0d", i), wl[i], i == 3);
        chk("t3_done_cycle", dc, 7);
        chk("t3_busy_c1", b1, 1);

        xfer(14'h40, 15'd0, -1, -1, 2, dc, b1);
        chk("t4_done_cycle", dc, 2);
        chk("t4_busy_c1", b1, 1);
        repeat (4) @(negedge clk);
        chk("t4_busy_after", busy, 0);
        chk("t4_no_en", en_addr.size(), 0);
        chk("t4_done_pulses", done_cnt, 1);

        clear_logs();
        @(posedge clk); #1;
        cur_c = 0; start = 1'b1; start_addr = 14'h20; len = 15'd8; m_ready = 1'b1;
        @(posedge clk); #1;
        cur_c = 1; start = 1'b0;
        @(posedge clk); #1;
        cur_c = 2;
        @(posedge clk); #1;
        cur_c = 3; m_ready = 1'b0;
        @(posedge clk); #1;
        cur_c = 4; rst = 1'b1;
        @(negedge clk);
        chk("t5_buffered_valid", m_valid, 1);
        chk("t5_buffered_data", m_data, 'h20);
        @(posedge clk); #1;
        cur_c = 5; rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_ram_en", ram_en, 0);
        chk("t5_ram_addr", ram_addr, 0);
        chk("t5_m_valid", m_valid, 0);
        chk("t5_m_data", m_data, 0);
        chk("t5_m_last", m_last, 0);
        for (int c = 6; c < 11; c++) begin
            @(posedge clk); #1;
            cur_c = c;
        end
        @(negedge clk);
        n = 0;
        foreach (en_cyc[i]) if (en_cyc[i] > 4) n++;
        chk("t5_no_en_after_rst", n, 0);
        chk("t5_no_done", done_cnt, 0);
        m_ready = 1'b1;
        xfer(14'h30, 15'd3, -1, -1, -1, dc, b1);
        chk("t5_new_done_cycle", dc, 6);
        chk("t5_new_words", wd.size(), 3);
        foreach (wd[i]) chk($sformatf("t5_new_data_%0d", i), wd[i], 'h30 + i);
        foreach (wl[i]) chk($sformatf("t5_new_last_%0d", i), wl[i], i == 2);

`ifdef SP_RAM_READER_ABORT_EN
        clear_logs();
        @(posedge clk); #1;
        cur_c = 0; start = 1'b1; start_addr = 14'h0; len = 15'd16; m_ready = 1'b1;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
            cur_c = c; start = 1'b0;
        end
        @(posedge clk); #1;
        cur_c = 5; abort = 1'b1;
        @(negedge clk);
        chk("t6_no_en_c5", ram_en, 0);
        @(posedge clk); #1;
        cur_c = 6; abort = 1'b0;
        @(negedge clk);
        chk("t6_valid_c6", m_valid, 0);
        chk("t6_done_c6", done, 1);
        @(posedge clk); #1;
        cur_c = 7;
        @(negedge clk);
        chk("t6_busy_c7", busy, 0);
        chk("t6_en_c7", ram_en, 0);
        chk("t6_valid_c7", m_valid, 0);
        n = 0;
        foreach (en_cyc[i]) if (en_cyc[i] >= 5) n++;
        chk("t6_no_en_after_abort", n, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
